// File: rtl/stack_alu_sequencer_if.sv
// Token-stream and ALU-bus signal bundle for the stack ALU sequencer.
//
// Signals
//   tok_valid    token present on tok_kind/tok_data
//   tok_ready    sequencer accepts the token this cycle
//   tok_kind     00 operand, 01 add, 10 mul, 11 end-of-expression
//   tok_data     operand value (meaningful only for tok_kind = 00)
//   alu_opcode   signed opcode: -4 ADD, -3 MUL, -2 PUSH, -1 POP, 0 NOP
//   alu_in       value presented with PUSH
//   alu_out      ALU result
//   alu_overflow ALU overflow flag
//
// Modports
//   master  the sequencer: accepts tokens and drives the ALU opcode bus
//   slave   the environment: produces tokens and models the ALU
interface stack_alu_if #(
    parameter int N = 4
);
    logic                tok_valid;
    logic                tok_ready;
    logic [1:0]          tok_kind;
    logic [N-1:0]        tok_data;
    logic signed [2:0]   alu_opcode;
    logic [N-1:0]        alu_in;
    logic [N-1:0]        alu_out;
    logic                alu_overflow;

    modport master (
        input  tok_valid,
        input  tok_kind,
        input  tok_data,
        output tok_ready,
        output alu_opcode,
        output alu_in,
        input  alu_out,
        input  alu_overflow
    );

    modport slave (
        output tok_valid,
        output tok_kind,
        output tok_data,
        input  tok_ready,
        input  alu_opcode,
        input  alu_in,
        output alu_out,
        output alu_overflow
    );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Initiator-side driver for a stack-based ALU.
//
// Consumes a postfix (RPN) token stream and turns it into a sequence of
// PUSH / ADD / MUL / POP opcodes for the ALU. For an operator it issues the
// operation, samples the ALU result ALU_LAT cycles later, pops both operands
// and pushes the result back. An end token pops the final value and reports
// it with a one-cycle result_valid pulse.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   bus           stack_alu_if.master: token handshake and ALU opcode bus
//   result        final value of the last completed expression
//   result_valid  one-cycle pulse when result is updated
//   ovf_sticky    an ADD/MUL of the current expression overflowed
//   err_underflow operator at depth<2, or operand pushed at depth=DEPTH
//   err_depth     end-of-expression with depth != 1
//
// Parameters
//   N        operand/result width (must match the ALU)
//   DEPTH    ALU stack capacity in entries
//   ALU_LAT  cycles from opcode issue until alu_out/alu_overflow are valid (>= 1)
module stack_alu_sequencer #(
    parameter int N       = 4,
    parameter int DEPTH   = 512,
    parameter int ALU_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    stack_alu_if.master  bus,
    output logic [N-1:0] result,
    output logic         result_valid,
    output logic         ovf_sticky,
    output logic         err_underflow,
    output logic         err_depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    // Every issue state lasts ALU_LAT cycles: the issue cycle (wcnt == WLOAD)
    // followed by ALU_LAT-1 wait cycles. The next issue, or the sample of
    // alu_out in a *_WAIT state, therefore lands exactly ALU_LAT cycles later.
    localparam logic [CW-1:0] WLOAD = CW'(ALU_LAT - 1);

    localparam logic signed [2:0] OP_ADD  = 3'sb100;
    localparam logic signed [2:0] OP_MUL  = 3'sb101;
    localparam logic signed [2:0] OP_PUSH = 3'sb110;
    localparam logic signed [2:0] OP_POP  = 3'sb111;
    localparam logic signed [2:0] OP_NOP  = 3'sb000;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_ADD  = 2'b01;
    localparam logic [1:0] K_MUL  = 2'b10;
    localparam logic [1:0] K_END  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        PUSH,
        OP,
        OP_WAIT,
        POPA,
        POPB,
        PUSHR,
        FPOP,
        FPOP_WAIT,
        DONE,
        ERR
    } state_t;

    // Control state (reset)
    state_t         state, state_n;
    logic [CW-1:0]  wcnt, wcnt_n;
    logic [DW-1:0]  depth, depth_n;
    logic [N-1:0]   result_n;
    logic           ovf_n;
    logic           eu_n, ed_n;
    logic           clr_ovf, clr_ovf_n;

    // Data holding (no reset): operand to push, or the captured operator result
    logic [N-1:0]   data_q, data_n;
    logic           is_mul, is_mul_n;

    logic           accept;
    logic           issue;
    logic           wait_done;

    assign bus.tok_ready = (state == IDLE);
    assign accept        = bus.tok_valid && (state == IDLE);
    assign issue         = (wcnt == WLOAD);
    assign wait_done     = (wcnt == '0);
    assign result_valid  = (state == DONE);

    // Next-state and register-update logic
    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        depth_n   = depth;
        result_n  = result;
        ovf_n     = ovf_sticky;
        eu_n      = err_underflow;
        ed_n      = err_depth;
        clr_ovf_n = clr_ovf;
        data_n    = data_q;
        is_mul_n  = is_mul;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    // First token after a completed expression starts a new one.
                    if (clr_ovf) begin
                        ovf_n     = 1'b0;
                        clr_ovf_n = 1'b0;
                    end
                    unique case (bus.tok_kind)
                        K_OPND: begin
                            if (depth == DW'(DEPTH)) begin
                                state_n = ERR;
                                eu_n    = 1'b1;
                            end else begin
                                state_n = PUSH;
                                data_n  = bus.tok_data;
                                wcnt_n  = WLOAD;
                            end
                        end
                        K_ADD, K_MUL: begin
                            if (depth < DW'(2)) begin
                                state_n = ERR;
                                eu_n    = 1'b1;
                            end else begin
                                state_n  = OP;
                                is_mul_n = (bus.tok_kind == K_MUL);
                                wcnt_n   = WLOAD;
                            end
                        end
                        K_END: begin
                            if (depth != DW'(1)) begin
                                state_n = ERR;
                                ed_n    = 1'b1;
                            end else begin
                                state_n = FPOP;
                                wcnt_n  = WLOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            PUSH: begin
                if (wait_done) begin
                    depth_n = depth + 1'b1;
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end

            OP: begin
                if (wait_done) begin
                    state_n = OP_WAIT;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end

            OP_WAIT: begin
                data_n  = bus.alu_out;
                ovf_n   = ovf_sticky | bus.alu_overflow;
                state_n = POPA;
                wcnt_n  = WLOAD;
            end

            POPA: begin
                if (wait_done) begin
                    depth_n = depth - 1'b1;
                    state_n = POPB;
                    wcnt_n  = WLOAD;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end

            POPB: begin
                if (wait_done) begin
                    depth_n = depth - 1'b1;
                    state_n = PUSHR;
                    wcnt_n  = WLOAD;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end

            PUSHR: begin
                if (wait_done) begin
                    depth_n = depth + 1'b1;
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end

            FPOP: begin
                if (wait_done) begin
                    state_n = FPOP_WAIT;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end

            FPOP_WAIT: begin
                result_n = bus.alu_out;
                depth_n  = '0;
                state_n  = DONE;
            end

            DONE: begin
                // ovf_sticky stays visible until the next expression begins.
                clr_ovf_n = 1'b1;
                state_n   = IDLE;
            end

            ERR: begin
                state_n = ERR;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Opcode bus: each opcode is driven only on the first cycle of its state.
    always_comb begin
        bus.alu_opcode = OP_NOP;
        bus.alu_in     = '0;
        if (issue) begin
            unique case (state)
                PUSH, PUSHR: begin
                    bus.alu_opcode = OP_PUSH;
                    bus.alu_in     = data_q;
                end
                OP:               bus.alu_opcode = is_mul ? OP_MUL : OP_ADD;
                POPA, POPB, FPOP: bus.alu_opcode = OP_POP;
                default:          bus.alu_opcode = OP_NOP;
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wcnt          <= '0;
            depth         <= '0;
            result        <= '0;
            ovf_sticky    <= 1'b0;
            err_underflow <= 1'b0;
            err_depth     <= 1'b0;
            clr_ovf       <= 1'b0;
        end else begin
            state         <= state_n;
            wcnt          <= wcnt_n;
            depth         <= depth_n;
            result        <= result_n;
            ovf_sticky    <= ovf_n;
            err_underflow <= eu_n;
            err_depth     <= ed_n;
            clr_ovf       <= clr_ovf_n;
        end
    end

    // Data registers
    always_ff @(posedge clk) begin
        data_q <= data_n;
        is_mul <= is_mul_n;
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
module tb_stack_alu_sequencer;

    localparam int N     = 4;
    localparam int DEPTH = 512;
    localparam int LAT   = 3;

    localparam logic signed [2:0] OP_ADD  = 3'sb100;
    localparam logic signed [2:0] OP_MUL  = 3'sb101;
    localparam logic signed [2:0] OP_PUSH = 3'sb110;
    localparam logic signed [2:0] OP_POP  = 3'sb111;

    localparam logic [7:0] T_ADD = 8'h40;
    localparam logic [7:0] T_MUL = 8'h80;
    localparam logic [7:0] T_END = 8'hC0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_alu_if #(.N(N)) bus();

    logic [N-1:0] result;
    logic         result_valid, ovf_sticky, err_underflow, err_depth;

    stack_alu_sequencer #(.N(N), .DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .result        (result),
        .result_valid  (result_valid),
        .ovf_sticky    (ovf_sticky),
        .err_underflow (err_underflow),
        .err_depth     (err_depth)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] O(input int v);
        logic [7:0] t;
        t = 8'h00 | 8'(v & 4'hF);
        return t;
    endfunction

    // ---------------- ALU stack model ----------------
    logic [N-1:0]      stk [0:DEPTH+7];
    int                sp = 0, peak = 0, cyc = 0, due = -100;
    int                n_arith = 0, dbl = 0, alu_bad = 0;
    logic [N-1:0]      dval = '0;
    logic              dovf = 1'b0;
    logic              prev_nz = 1'b0;
    logic signed [2:0] op_s;
    logic [N:0]        sum_s;
    logic [2*N-1:0]    prod_s;
    logic signed [2:0] oplog [$];
    logic [N-1:0]      vallog [$];

    always @(posedge clk) begin
        if (rst) begin
            sp = 0; peak = 0; n_arith = 0; dbl = 0; prev_nz = 1'b0; due = -100;
            oplog.delete(); vallog.delete();
        end else begin
            op_s = bus.alu_opcode;
            if (op_s != 3'sb000) begin
                oplog.push_back(op_s);
                vallog.push_back(bus.alu_in);
                if (prev_nz) dbl++;
            end
            prev_nz = (op_s != 3'sb000);
            if (op_s == OP_PUSH) begin
                if (sp < DEPTH) begin
                    stk[sp] = bus.alu_in; sp++;
                    if (sp > peak) peak = sp;
                end else alu_bad++;
            end else if (op_s == OP_ADD || op_s == OP_MUL) begin
                if (sp >= 2) begin
                    n_arith++;
                    if (op_s == OP_ADD) begin
                        sum_s = {1'b0, stk[sp-1]} + {1'b0, stk[sp-2]};
                        dval  = sum_s[N-1:0];
                        dovf  = sum_s[N];
                    end else begin
                        prod_s = {{N{1'b0}}, stk[sp-1]} * {{N{1'b0}}, stk[sp-2]};
                        dval   = prod_s[N-1:0];
                        dovf   = |prod_s[2*N-1:N];
                    end
                    due = cyc + LAT;
                end else alu_bad++;
            end else if (op_s == OP_POP) begin
                if (sp >= 1) begin
                    dval = stk[sp-1]; dovf = 1'b0; sp--;
                    due  = cyc + LAT;
                end else alu_bad++;
            end
        end
        cyc++;
    end

    // ALU outputs are only meaningful exactly ALU_LAT cycles after issue.
    always @(negedge clk) begin
        bus.alu_out      = (cyc == due) ? dval : ~dval;
        bus.alu_overflow = (cyc == due) ? dovf : 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_tok(input logic [7:0] t, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        bus.tok_valid = 1'b1;
        bus.tok_kind  = t[7:6];
        bus.tok_data  = t[N-1:0];
        for (int i = 0; i < 40; i++) begin
            if (bus.tok_ready) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        bus.tok_valid = 1'b0;
        bus.tok_data  = ~t[N-1:0];
    endtask

    task automatic send_seq(input logic [63:0] toks, input int n, output int nacc);
        bit a;
        logic [7:0] t;
        nacc = 0;
        for (int i = 0; i < n; i++) begin
            t = toks[63-8*i -: 8];
            send_tok(t, a);
            if (a) nacc++;
        end
    endtask

    task automatic wait_result(input string name, output logic [N-1:0] res, output logic ov);
        bit got;
        got = 1'b0; res = '0; ov = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1; res = result; ov = ovf_sticky;
                break;
            end
        end
        check({name, "_result_valid_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        check({name, "_pulse_width"}, 32'(result_valid), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0] toks;
        int          ntok;
        int          exp_acc;
        bit          exp_valid;
        logic [3:0]  exp_res;
        bit          exp_ovf;
        bit          exp_eu;
        bit          exp_ed;
        int          exp_arith;
        int          exp_peak;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int           nacc;
        bit           a;
        logic [N-1:0] res;
        logic         ov;
        string        nm;
        logic signed [2:0] exp_ops [7];
        logic [N-1:0]      exp_vals [7];

        bus.tok_valid = 1'b0;
        bus.tok_kind  = 2'b00;
        bus.tok_data  = '0;

        vecs.push_back('{{O(3), O(4), T_ADD, T_END, 32'h0}, 4, 4, 1, 4'd7, 0, 0, 0, 1, 2});
        vecs.push_back('{{O(9), O(2), T_MUL, T_END, 32'h0}, 4, 4, 1, 4'd2, 1, 0, 0, 1, 2});
        vecs.push_back('{{O(2), O(3), O(4), T_MUL, T_ADD, T_END, 16'h0}, 6, 6, 1, 4'd14, 0, 0, 0, 2, 3});
        vecs.push_back('{{O(5), T_ADD, 48'h0}, 2, 2, 0, 4'd0, 0, 1, 0, 0, 1});
        vecs.push_back('{{O(1), O(2), T_END, O(3), 32'h0}, 4, 3, 0, 4'd0, 0, 0, 1, 0, 2});
        vecs.push_back('{{T_END, 56'h0}, 1, 1, 0, 4'd0, 0, 0, 1, 0, 0});
        vecs.push_back('{{T_ADD, O(1), 48'h0}, 2, 1, 0, 4'd0, 0, 1, 0, 0, 0});
        vecs.push_back('{{O(15), O(15), T_ADD, O(15), T_MUL, T_END, 16'h0}, 6, 6, 1, 4'd2, 1, 0, 0, 2, 2});

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_result",       32'(result),         32'd0);
        check("rst_result_valid", 32'(result_valid),   32'd0);
        check("rst_ovf",          32'(ovf_sticky),     32'd0);
        check("rst_err_underflow",32'(err_underflow),  32'd0);
        check("rst_err_depth",    32'(err_depth),      32'd0);
        check("rst_opcode",       32'(bus.alu_opcode), 32'd0);
        check("rst_alu_in",       32'(bus.alu_in),     32'd0);
        check("rst_tok_ready",    32'(bus.tok_ready),  32'd1);

        // Table-driven expressions
        for (int v = 0; v < vecs.size(); v++) begin
            nm = $sformatf("vec%0d", v);
            do_reset();
            send_seq(vecs[v].toks, vecs[v].ntok, nacc);
            check({nm, "_accepted"}, 32'(nacc), 32'(vecs[v].exp_acc));
            if (vecs[v].exp_valid) begin
                wait_result(nm, res, ov);
                check({nm, "_result"}, 32'(res), 32'(vecs[v].exp_res));
                check({nm, "_ovf"},    32'(ov),  32'(vecs[v].exp_ovf));
            end else begin
                repeat (2) @(negedge clk);
            end
            check({nm, "_err_underflow"}, 32'(err_underflow), 32'(vecs[v].exp_eu));
            check({nm, "_err_depth"},     32'(err_depth),     32'(vecs[v].exp_ed));
            check({nm, "_tok_ready"},     32'(bus.tok_ready), 32'(!(vecs[v].exp_eu || vecs[v].exp_ed)));
            check({nm, "_arith_ops"},     32'(n_arith),       32'(vecs[v].exp_arith));
            check({nm, "_depth_peak"},    32'(peak),          32'(vecs[v].exp_peak));
            check({nm, "_single_cycle_ops"}, 32'(dbl),        32'd0);
        end

        // Opcode trace of 3,4,add,end
        exp_ops  = '{OP_PUSH, OP_PUSH, OP_ADD, OP_POP, OP_POP, OP_PUSH, OP_POP};
        exp_vals = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0};
        do_reset();
        send_seq({O(3), O(4), T_ADD, T_END, 32'h0}, 4, nacc);
        wait_result("trace", res, ov);
        check("trace_len", 32'(oplog.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < oplog.size()) begin
                check($sformatf("trace_op%0d", i),  32'(oplog[i]),  32'(exp_ops[i]));
                check($sformatf("trace_val%0d", i), 32'(vallog[i]), 32'(exp_vals[i]));
            end
        end

        // ovf_sticky survives DONE and clears on the next accepted token
        do_reset();
        send_seq({O(9), O(2), T_MUL, T_END, 32'h0}, 4, nacc);
        wait_result("ovfclr_a", res, ov);
        check("ovfclr_a_ovf_at_pulse", 32'(ov), 32'd1);
        check("ovfclr_a_ovf_after",    32'(ovf_sticky), 32'd1);
        send_tok(O(1), a);
        @(negedge clk);
        check("ovfclr_cleared_on_token", 32'(ovf_sticky), 32'd0);
        send_seq({O(1), T_ADD, T_END, 40'h0}, 3, nacc);
        wait_result("ovfclr_b", res, ov);
        check("ovfclr_b_result", 32'(res), 32'd2);
        check("ovfclr_b_ovf",    32'(ov),  32'd0);

        // Reset asserted while the sequencer is in OP_WAIT
        do_reset();
        send_seq({O(3), O(4), T_ADD, T_END, 32'h0}, 4, nacc);
        wait_result("midrst_pre", res, ov);
        check("midrst_pre_result", 32'(res), 32'd7);
        send_seq({O(9), O(2), T_MUL, 40'h0}, 3, nacc);
        @(negedge clk);
        check("midrst_mul_issued", 32'(bus.alu_opcode), 32'(OP_MUL));
        repeat (LAT) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_result",       32'(result),         32'd0);
        check("midrst_result_valid", 32'(result_valid),   32'd0);
        check("midrst_ovf",          32'(ovf_sticky),     32'd0);
        check("midrst_errs",         32'({err_underflow, err_depth}), 32'd0);
        check("midrst_opcode",       32'(bus.alu_opcode), 32'd0);
        check("midrst_alu_in",       32'(bus.alu_in),     32'd0);
        check("midrst_tok_ready",    32'(bus.tok_ready),  32'd1);
        send_seq({O(1), O(1), T_ADD, T_END, 32'h0}, 4, nacc);
        wait_result("midrst_post", res, ov);
        check("midrst_post_result", 32'(res), 32'd2);
        check("midrst_post_arith",  32'(n_arith), 32'd1);

        // Push at full depth
        do_reset();
        nacc = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_tok(O(i), a);
            if (a) nacc++;
        end
        @(negedge clk);
        check("full_accepted",      32'(nacc),          32'(DEPTH + 1));
        check("full_peak",          32'(peak),          32'(DEPTH));
        check("full_err_underflow", 32'(err_underflow), 32'd1);
        check("full_err_depth",     32'(err_depth),     32'd0);
        check("full_tok_ready",     32'(bus.tok_ready), 32'd0);
        send_tok(T_END, a);
        check("full_no_more_tokens", 32'(a), 32'd0);

        check("alu_protocol_errors", 32'(alu_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
